// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - mode inputs and raster outputs of the video timing generator
// Bundles the programmable mode, the advance qualifier and the raster outputs.
interface video_timing_gen_if #(
    parameter int busWidth = 12
);
    logic                enable;
    logic [busWidth-1:0] resHorizontal;
    logic [busWidth-1:0] hFrontPorch;
    logic [busWidth-1:0] hSyncWidth;
    logic [busWidth-1:0] hBackPorch;
    logic [busWidth-1:0] resVertical;
    logic [busWidth-1:0] vFrontPorch;
    logic [busWidth-1:0] vSyncWidth;
    logic [busWidth-1:0] vBackPorch;
    logic                hSyncPolarity;
    logic                vSyncPolarity;
    logic [busWidth-1:0] hCount;
    logic [busWidth-1:0] vCount;
    logic                hSync;
    logic                vSync;
    logic                lineStart;
    logic                frameStart;
    logic                configError;

    modport master (
        output enable, resHorizontal, hFrontPorch, hSyncWidth, hBackPorch,
               resVertical, vFrontPorch, vSyncWidth, vBackPorch,
               hSyncPolarity, vSyncPolarity,
        input  hCount, vCount, hSync, vSync, lineStart, frameStart, configError
    );

    modport slave (
        input  enable, resHorizontal, hFrontPorch, hSyncWidth, hBackPorch,
               resVertical, vFrontPorch, vSyncWidth, vBackPorch,
               hSyncPolarity, vSyncPolarity,
        output hCount, vCount, hSync, vSync, lineStart, frameStart, configError
    );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster counter and sync generator with frame-boundary mode shadowing
// Counts and syncs are registered together so syncs describe the counts shown in the same cycle.
module video_timing_gen #(
    parameter int busWidth = 12
) (
    input logic               clock,
    input logic               reset,
    video_timing_gen_if.slave bus
);
    localparam int TW = busWidth + 2;
    localparam logic [TW-1:0] MAX_TOTAL = {2'b01, {busWidth{1'b0}}};

    typedef logic [busWidth-1:0] cnt_t;
    typedef logic [TW-1:0]       wide_t;
    typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;

    function automatic wide_t f_wide(input cnt_t a);
        return {2'b00, a};
    endfunction

    function automatic wide_t f_total(input cnt_t a, input cnt_t b, input cnt_t c, input cnt_t d);
        return f_wide(a) + f_wide(b) + f_wide(c) + f_wide(d);
    endfunction

    function automatic logic f_valid(input cnt_t res, input cnt_t sw, input wide_t tot);
        return (res != '0) && (sw != '0) && (tot >= wide_t'(2)) && (tot <= MAX_TOTAL);
    endfunction

    function automatic logic f_in_sync(input cnt_t cnt, input cnt_t res, input cnt_t fp, input cnt_t sw);
        wide_t start;
        start = f_wide(res) + f_wide(fp);
        return (f_wide(cnt) >= start) && (f_wide(cnt) < start + f_wide(sw));
    endfunction

    state_t r_state;
    cnt_t   r_hRes, r_hFp, r_hSw, r_hBp, r_vRes, r_vFp, r_vSw, r_vBp;
    logic   r_hPol, r_vPol;
    cnt_t   r_hCount, r_vCount;
    logic   r_hSync, r_vSync, r_lineStart, r_frameStart, r_configError;

    wide_t w_sh_hTotal, w_sh_vTotal, w_in_hTotal, w_in_vTotal;
    logic  w_sh_valid, w_in_valid, w_hLast, w_vLast, w_latch;
    cnt_t  w_hNext, w_vNext;

    assign w_sh_hTotal = f_total(r_hRes, r_hFp, r_hSw, r_hBp);
    assign w_sh_vTotal = f_total(r_vRes, r_vFp, r_vSw, r_vBp);
    assign w_sh_valid  = f_valid(r_hRes, r_hSw, w_sh_hTotal) && f_valid(r_vRes, r_vSw, w_sh_vTotal);
    assign w_in_hTotal = f_total(bus.resHorizontal, bus.hFrontPorch, bus.hSyncWidth, bus.hBackPorch);
    assign w_in_vTotal = f_total(bus.resVertical, bus.vFrontPorch, bus.vSyncWidth, bus.vBackPorch);
    assign w_in_valid  = f_valid(bus.resHorizontal, bus.hSyncWidth, w_in_hTotal) &&
                         f_valid(bus.resVertical, bus.vSyncWidth, w_in_vTotal);

    assign w_hLast = (f_wide(r_hCount) == w_sh_hTotal - wide_t'(1));
    assign w_vLast = (f_wide(r_vCount) == w_sh_vTotal - wide_t'(1));
    assign w_hNext = w_hLast ? '0 : r_hCount + cnt_t'(1);
    assign w_vNext = w_hLast ? (w_vLast ? '0 : r_vCount + cnt_t'(1)) : r_vCount;

    // Shadow reload points: reset/idle, every enabled error cycle, and the enabled last pixel of a frame.
    assign w_latch = reset ||
                     ((r_state == IDLE) && !bus.enable) ||
                     ((r_state == ERROR) && bus.enable) ||
                     ((r_state == RUN) && bus.enable && w_hLast && w_vLast);

    // Capture the mode inputs into the shadow registers at reload points only.
    always_ff @(posedge clock) begin
        if (w_latch) begin
            r_hRes <= bus.resHorizontal;
            r_hFp  <= bus.hFrontPorch;
            r_hSw  <= bus.hSyncWidth;
            r_hBp  <= bus.hBackPorch;
            r_vRes <= bus.resVertical;
            r_vFp  <= bus.vFrontPorch;
            r_vSw  <= bus.vSyncWidth;
            r_vBp  <= bus.vBackPorch;
            r_hPol <= bus.hSyncPolarity;
            r_vPol <= bus.vSyncPolarity;
        end
    end

    // Raster FSM; a valid mode has res>=1 so (0,0) is never inside a sync window, hence syncs go inactive there.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_hCount      <= '0;
            r_vCount      <= '0;
            r_hSync       <= ~bus.hSyncPolarity;
            r_vSync       <= ~bus.vSyncPolarity;
            r_lineStart   <= 1'b0;
            r_frameStart  <= 1'b0;
            r_configError <= 1'b0;
        end else begin
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.enable) begin
                        r_hSync <= ~r_hPol;
                        r_vSync <= ~r_vPol;
                        if (w_sh_valid) begin
                            r_state      <= RUN;
                            r_lineStart  <= 1'b1;
                            r_frameStart <= 1'b1;
                        end else begin
                            r_state       <= ERROR;
                            r_configError <= 1'b1;
                        end
                    end else begin
                        r_hSync <= ~bus.hSyncPolarity;
                        r_vSync <= ~bus.vSyncPolarity;
                    end
                end
                RUN: begin
                    if (bus.enable) begin
                        if (w_hLast && w_vLast) begin
                            r_hCount <= '0;
                            r_vCount <= '0;
                            r_hSync  <= ~bus.hSyncPolarity;
                            r_vSync  <= ~bus.vSyncPolarity;
                            if (w_in_valid) begin
                                r_lineStart  <= 1'b1;
                                r_frameStart <= 1'b1;
                            end else begin
                                r_state       <= ERROR;
                                r_configError <= 1'b1;
                            end
                        end else begin
                            r_hCount    <= w_hNext;
                            r_vCount    <= w_vNext;
                            r_lineStart <= w_hLast;
                            r_hSync     <= f_in_sync(w_hNext, r_hRes, r_hFp, r_hSw) ? r_hPol : ~r_hPol;
                            r_vSync     <= f_in_sync(w_vNext, r_vRes, r_vFp, r_vSw) ? r_vPol : ~r_vPol;
                        end
                    end
                end
                ERROR: begin
                    if (bus.enable) begin
                        r_hSync <= ~bus.hSyncPolarity;
                        r_vSync <= ~bus.vSyncPolarity;
                        if (w_in_valid) begin
                            r_state       <= RUN;
                            r_configError <= 1'b0;
                            r_lineStart   <= 1'b1;
                            r_frameStart  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.hCount      = r_hCount;
    assign bus.vCount      = r_vCount;
    assign bus.hSync       = r_hSync;
    assign bus.vSync       = r_vSync;
    assign bus.lineStart   = r_lineStart;
    assign bus.frameStart  = r_frameStart;
    assign bus.configError = r_configError;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized bench with a behavioural raster model for video_timing_gen
module tb_video_timing_gen;
    localparam int BW = 12;

    typedef struct {
        int hr, hf, hs, hb, vr, vf, vs, vb;
        bit hp, vp;
    } mode_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    bit   checking = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    video_timing_gen_if #(.busWidth(BW)) bus ();
    video_timing_gen #(.busWidth(BW)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // Behavioural model: phase 0 idle, 1 running, 2 error; position (mh,mv) inside the raster.
    int    m_phase = 0;
    int    mh = 0, mv = 0;
    bit    e_ls = 1'b0, e_fs = 1'b0;
    mode_t sh;

    function automatic int htot(input mode_t m); return m.hr + m.hf + m.hs + m.hb; endfunction
    function automatic int vtot(input mode_t m); return m.vr + m.vf + m.vs + m.vb; endfunction
    function automatic bit mode_ok(input mode_t m);
        return m.hr >= 1 && m.vr >= 1 && m.hs >= 1 && m.vs >= 1 &&
               htot(m) >= 2 && vtot(m) >= 2 && htot(m) <= (1 << BW) && vtot(m) <= (1 << BW);
    endfunction

    function automatic mode_t in_mode();
        mode_t m;
        m.hr = int'(bus.resHorizontal); m.hf = int'(bus.hFrontPorch);
        m.hs = int'(bus.hSyncWidth);    m.hb = int'(bus.hBackPorch);
        m.vr = int'(bus.resVertical);   m.vf = int'(bus.vFrontPorch);
        m.vs = int'(bus.vSyncWidth);    m.vb = int'(bus.vBackPorch);
        m.hp = bus.hSyncPolarity;       m.vp = bus.vSyncPolarity;
        return m;
    endfunction

    always @(posedge clock) begin
        mode_t cin;
        cin = in_mode();
        if (reset) begin
            m_phase = 0; sh = cin; mh = 0; mv = 0; e_ls = 0; e_fs = 0;
        end else begin
            e_ls = 0; e_fs = 0;
            if (m_phase == 0) begin
                if (bus.enable) begin
                    if (mode_ok(sh)) begin m_phase = 1; e_ls = 1; e_fs = 1; end
                    else m_phase = 2;
                end else sh = cin;
            end else if (m_phase == 1) begin
                if (bus.enable) begin
                    mh++;
                    if (mh == htot(sh)) begin
                        mh = 0; mv++; e_ls = 1;
                        if (mv == vtot(sh)) begin
                            mv = 0; sh = cin;
                            if (mode_ok(sh)) e_fs = 1;
                            else begin m_phase = 2; e_ls = 0; end
                        end
                    end
                end
            end else if (bus.enable) begin
                sh = cin;
                if (mode_ok(sh)) begin m_phase = 1; e_ls = 1; e_fs = 1; end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (checking) begin
            bit hs_on, vs_on;
            hs_on = (m_phase == 1) && mh >= sh.hr + sh.hf && mh < sh.hr + sh.hf + sh.hs;
            vs_on = (m_phase == 1) && mv >= sh.vr + sh.vf && mv < sh.vr + sh.vf + sh.vs;
            chk("hCount", int'(bus.hCount), mh);
            chk("vCount", int'(bus.vCount), mv);
            chk("hSync", int'(bus.hSync), int'(hs_on ? sh.hp : !sh.hp));
            chk("vSync", int'(bus.vSync), int'(vs_on ? sh.vp : !sh.vp));
            chk("lineStart", int'(bus.lineStart), int'(e_ls));
            chk("frameStart", int'(bus.frameStart), int'(e_fs));
            chk("configError", int'(bus.configError), int'(m_phase == 2));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_mode(input mode_t m);
        bus.resHorizontal = BW'(m.hr); bus.hFrontPorch = BW'(m.hf);
        bus.hSyncWidth    = BW'(m.hs); bus.hBackPorch  = BW'(m.hb);
        bus.resVertical   = BW'(m.vr); bus.vFrontPorch = BW'(m.vf);
        bus.vSyncWidth    = BW'(m.vs); bus.vBackPorch  = BW'(m.vb);
        bus.hSyncPolarity = m.hp;      bus.vSyncPolarity = m.vp;
    endtask

    task automatic restart(input mode_t m);
        set_mode(m); reset = 1'b1; step(2); reset = 1'b0; bus.enable = 1'b1; step(1);
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(m_phase == 1 && mh == h && mv == v) && n < 400) begin step(1); n++; end
        chk("reach_pos", int'(n < 400), 1);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin step(1); n++; end while (!bus.frameStart && n < 500);
    endtask

    task automatic rnd_mode(output mode_t m);
        m.hr = $urandom_range(0, 5); m.hf = $urandom_range(0, 3);
        m.hs = $urandom_range(0, 3); m.hb = $urandom_range(0, 3);
        m.vr = $urandom_range(0, 4); m.vf = $urandom_range(0, 2);
        m.vs = $urandom_range(0, 2); m.vb = $urandom_range(0, 2);
        m.hp = 1'($urandom); m.vp = 1'($urandom);
    endtask

    initial begin
        mode_t base, m;
        int nf, nl, nh, nv, n, hmax;

        // Basic 8x6 mode, active-high syncs.
        base = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
        set_mode(base); bus.enable = 1'b0; reset = 1'b1;
        step(2);
        checking = 1'b1;
        chk("rst_hCount", int'(bus.hCount), 0);
        chk("rst_hSync", int'(bus.hSync), 0);
        chk("rst_vSync", int'(bus.vSync), 0);
        chk("rst_cfgErr", int'(bus.configError), 0);
        reset = 1'b0; bus.enable = 1'b1; step(1);
        chk("start_fs", int'(bus.frameStart), 1);
        chk("start_ls", int'(bus.lineStart), 1);
        step(5);
        chk("h5_hCount", int'(bus.hCount), 5);
        chk("h5_hSync", int'(bus.hSync), 1);
        nf = 0; nl = 0; nh = 0; nv = 0;
        for (int i = 0; i < 96; i++) begin
            step(1);
            nf += int'(bus.frameStart); nl += int'(bus.lineStart);
            nh += int'(bus.hSync); nv += int'(bus.vSync);
        end
        chk("cnt_fs", nf, 2); chk("cnt_ls", nl, 12);
        chk("cnt_hSync", nh, 24); chk("cnt_vSync", nv, 16);

        // Same mode, active-low syncs.
        base.hp = 1'b0; base.vp = 1'b0;
        set_mode(base); reset = 1'b1; step(2);
        chk("rstlow_hSync", int'(bus.hSync), 1);
        chk("rstlow_vSync", int'(bus.vSync), 1);
        reset = 1'b0; step(1);
        chk("startlow_fs", int'(bus.frameStart), 1);
        nh = 0; nv = 0;
        for (int i = 0; i < 96; i++) begin
            step(1); nh += int'(!bus.hSync); nv += int'(!bus.vSync);
        end
        chk("cntlow_hSync", nh, 24); chk("cntlow_vSync", nv, 16);

        // Mid-frame mode change takes effect only at the frame boundary.
        wait_pos(3, 2);
        m = base; m.hr = 6; set_mode(m);
        wait_fs(n); chk("mid_to_fs", n, 29);
        wait_fs(n); chk("new_frame_len", n, 60);
        step(7);
        chk("new_h7_hCount", int'(bus.hCount), 7);
        chk("new_h7_hSync", int'(bus.hSync), 0);

        // Freeze with enable low.
        wait_pos(2, 1);
        bus.enable = 1'b0; step(5);
        chk("frz_hCount", int'(bus.hCount), 2);
        chk("frz_vCount", int'(bus.vCount), 1);
        bus.enable = 1'b1; step(1);
        chk("resume_hCount", int'(bus.hCount), 3);

        // Invalid mode at reset exit, then recovery.
        m.hs = 0; restart(m);
        chk("err_cfg", int'(bus.configError), 1);
        chk("err_hCount", int'(bus.hCount), 0);
        m.hs = 2; set_mode(m); step(1);
        chk("rec_cfg", int'(bus.configError), 0);
        chk("rec_fs", int'(bus.frameStart), 1);

        // Reset mid-frame.
        wait_pos(6, 4);
        reset = 1'b1; step(1);
        chk("midrst_hCount", int'(bus.hCount), 0);
        chk("midrst_vCount", int'(bus.vCount), 0);
        chk("midrst_ls", int'(bus.lineStart), 0);
        reset = 1'b0; step(1);
        chk("midrst_fs", int'(bus.frameStart), 1);

        // Randomized modes, enable gaps, mid-frame changes and occasional resets.
        for (int it = 0; it < 25; it++) begin
            rnd_mode(m); set_mode(m);
            reset = 1'b1; step(1 + int'($urandom_range(0, 1))); reset = 1'b0;
            for (int c = 0; c < 250; c++) begin
                bus.enable = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 59) == 0) begin rnd_mode(m); set_mode(m); end
                reset = ($urandom_range(0, 199) == 0);
                step(1);
            end
        end
        reset = 1'b0;

        // 1080p line wrap.
        m = '{1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1, 1'b1};
        restart(m);
        n = 0; hmax = 0;
        while (int'(bus.hCount) != 2199 && n < 2300) begin
            step(1); n++;
            if (int'(bus.hCount) > hmax) hmax = int'(bus.hCount);
        end
        chk("p1080_reach", int'(n < 2300), 1);
        chk("p1080_max", hmax, 2199);
        step(1);
        chk("p1080_wrap_h", int'(bus.hCount), 0);
        chk("p1080_wrap_v", int'(bus.vCount), 1);
        chk("p1080_wrap_ls", int'(bus.lineStart), 1);

        // Total limits: 4096 valid, 4097 invalid, untruncated sum invalid.
        m = '{4000, 90, 4, 2, 1, 0, 1, 0, 1'b1, 1'b1};
        restart(m); chk("tot4096_cfg", int'(bus.configError), 0);
        m.hb = 3;
        restart(m); chk("tot4097_cfg", int'(bus.configError), 1);
        m = '{4095, 4095, 4095, 4095, 1, 0, 1, 0, 1'b1, 1'b1};
        restart(m); chk("totwide_cfg", int'(bus.configError), 1);
        step(2);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Raster timing generator for the HDMI output path. Produces the horizontal and vertical pixel counters (hCount/vCount) and the hSync/vSync pulses for a programmable video mode. It feeds the data-enable stage directly downstream, which compares hCount/vCount against the active resolution. That stage must be instantiated with the same busWidth. Mode registers are shadowed and change only on frame boundaries, so the raster never tears.

Parameters:
busWidth, 12, width of every count/config bus; 12 bits covers 1080p totals (2200 x 1125).

Ports:
clock  input  1  pixel clock
reset  input  1  synchronous, active-high reset
enable  input  1  count-advance qualifier; low = freeze raster
resHorizontal  input  busWidth  active pixels per line (e.g. 1920)
hFrontPorch  input  busWidth  h front porch in pixels
hSyncWidth  input  busWidth  hSync pulse width in pixels
hBackPorch  input  busWidth  h back porch in pixels
resVertical  input  busWidth  active lines per frame (e.g. 1080)
vFrontPorch  input  busWidth  v front porch in lines
vSyncWidth  input  busWidth  vSync pulse width in lines
vBackPorch  input  busWidth  v back porch in lines
hSyncPolarity  input  1  hSync level while asserted (1 = active-high)
vSyncPolarity  input  1  vSync level while asserted
hCount  output  busWidth  horizontal position, 0..hTotal-1
vCount  output  busWidth  vertical position, 0..vTotal-1
hSync  output  1  horizontal sync
vSync  output  1  vertical sync
lineStart  output  1  one-cycle pulse when hCount==0
frameStart  output  1  one-cycle pulse when hCount==0 and vCount==0
configError  output  1  high while the latched mode is invalid

Behaviour:
- Totals: hTotal = resHorizontal+hFrontPorch+hSyncWidth+hBackPorch. vTotal is formed the same way. Both are computed at busWidth+2 bits, with no truncation.
- Config valid when: res>=1, syncWidth>=1, hTotal>=2, vTotal>=2, and each total <= 2^busWidth. Porches may be 0.
- All outputs are registered. hSync, vSync, lineStart and frameStart in cycle t describe the hCount/vCount presented in cycle t, so there is zero skew between counts and syncs.
- hSync is asserted (= hSyncPolarity) iff res+hFp <= hCount < res+hFp+hSyncWidth. Otherwise it outputs the inactive level (~polarity).
- vSync is asserted iff resV+vFp <= vCount < resV+vFp+vSyncWidth, evaluated on the vCount value. It changes only when hCount becomes 0.
- FSM states: IDLE, RUN, ERROR.
- IDLE: entered whenever reset=1, in any state and mid-frame.
  - Outputs: hCount=0, vCount=0, hSync=~hSyncPolarity, vSync=~vSyncPolarity, lineStart=0, frameStart=0, configError=0.
  - Mode inputs are latched into shadow registers.
- IDLE -> RUN: on the first edge with reset=0 and enable=1, if the shadow config is valid. Counts stay (0,0); lineStart=1 and frameStart=1.
- IDLE -> ERROR: same edge, config invalid. configError=1.
- RUN with enable=1:
  - hCount increments.
  - At hCount==hTotal-1, hCount wraps to 0, lineStart pulses and vCount increments.
  - At vCount==vTotal-1 with hCount==hTotal-1, both wrap to 0, frameStart pulses, and the shadow registers reload from the inputs.
  - If the reloaded config is invalid: go to ERROR with counts 0 and no pulses.
- RUN with enable=0: counts and syncs hold, pulses are forced to 0, and no reload occurs.
- ERROR:
  - Counts are 0, syncs inactive, pulses 0, configError=1.
  - Inputs are re-latched every enabled cycle. When valid, go to RUN with counts (0,0), lineStart=frameStart=1, and configError cleared the same cycle.
- Mode inputs changed mid-frame have no effect until the frame boundary.
- Polarity inputs are shadowed together with the rest of the mode.

Test Plan:
- Mode hRes=4,hFp=1,hSync=2,hBp=1 (hTotal=8), vRes=3,vFp=1,vSync=1,vBp=1 (vTotal=6), polarities 1, reset 2 cycles then enable=1 -> hCount sequence 0..7 wrapping; hSync=1 exactly at hCount 5,6; vSync=1 for all 8 cycles of vCount=4; frameStart every 48 cycles; lineStart every 8.
- Same mode, polarities 0 -> hSync/vSync are exact inversions of the previous run; reset values are 1.
- Mid-frame at (3,2), change hRes to 6 -> timing unchanged until after (7,5); the next frame has hTotal=10 with hSync at hCount 7,8.
- Drop enable for 5 cycles at (2,1) -> counts and syncs frozen, no pulses; resumes at (3,1).
- hSyncWidth=0 at reset exit -> ERROR, configError=1, counts 0. Set hSyncWidth=2 -> next cycle counts (0,0) with frameStart=1 and configError=0.
- Assert reset at (6,4) -> the next cycle shows (0,0), syncs inactive, pulses 0. Deassert -> frameStart on the first enabled edge. Boundary check: 1920/88/44/148 with busWidth=12 -> hCount wraps at 2199.
